// File: rtl/btb_bimodal_predictor_if.sv
// Fetch/resolve-side bus of the BTB direction predictor.
// slave  : the predictor (consumes lookup PC and resolve updates)
// master : the pipeline (drives PCs, consumes predictions)
interface btb_bimodal_predictor_if #(
  parameter int WORD_W = 16
);
  // IF-stage lookup
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pred_next_pc;
  logic              pred_hit;
  logic              pred_taken;

  // Branch-resolve update
  logic              upd_valid;
  logic [WORD_W-1:0] upd_pc;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [WORD_W-1:0] upd_target;
  logic              upd_mispredict;

  // Performance
  logic [15:0]       perf_mispred;

  modport slave (
    input  pc,
    output pred_next_pc, pred_hit, pred_taken,
    input  upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_mispredict,
    output perf_mispred
  );

  modport master (
    output pc,
    input  pred_next_pc, pred_hit, pred_taken,
    output upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, upd_mispredict,
    input  perf_mispred
  );
endinterface

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped BTB with per-entry valid/tag/target and a CNT_W-bit
// saturating direction counter. Lookup is combinational; updates from the
// resolve stage commit on posedge clk. Optional build macro BTB_GSHARE_EN
// indexes the counter table with idx ^ global-history instead of idx.
module btb_bimodal_predictor #(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 8,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  btb_bimodal_predictor_if.slave        bus
);

  localparam int DEPTH = 1 << IDX_W;

  // Counter encodings: weakly not-taken (reset), weakly taken (allocate), strongly taken.
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [15:0] perf_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // State: valid bits and counters are reset; tag/target storage is not.
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][CNT_W-1:0]  cnt_q,   cnt_d;
  logic [15:0]                  perf_q,  perf_d;
  logic [TAG_W-1:0]             tag_ram [DEPTH];
  logic [WORD_W-1:0]            tgt_ram [DEPTH];

  // Lookup side decode
  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  lk_cidx;
  logic [TAG_W-1:0]  lk_tag;

  // Update side decode
  logic [IDX_W-1:0]  up_idx;
  logic [IDX_W-1:0]  up_cidx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              tag_we;
  logic              tgt_we;

  assign lk_idx = bus.pc[IDX_W-1:0];
  assign lk_tag = bus.pc[IDX_W+TAG_W-1:IDX_W];
  assign up_idx = bus.upd_pc[IDX_W-1:0];
  assign up_tag = bus.upd_pc[IDX_W+TAG_W-1:IDX_W];

`ifdef BTB_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Both lookup and update read the counter table through the pre-shift history.
  assign lk_cidx = lk_idx ^ ghr_q;
  assign up_cidx = up_idx ^ ghr_q;

  // History shifts in the resolved direction of conditional branches only.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.upd_valid && !bus.upd_is_jump) begin
      ghr_d = {ghr_q[IDX_W-2:0], bus.upd_taken};
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign lk_cidx = lk_idx;
  assign up_cidx = up_idx;
`endif

  // Zero-latency prediction from current (pre-update) table contents.
  always_comb begin
    bus.pred_hit     = valid_q[lk_idx] && (tag_ram[lk_idx] == lk_tag);
    bus.pred_taken   = bus.pred_hit && cnt_q[lk_cidx][CNT_W-1];
    bus.pred_next_pc = bus.pred_taken ? tgt_ram[lk_idx] : bus.pc + WORD_W'(1);
    bus.perf_mispred = perf_q;
  end

  // Next-state for valid bits, counters and the mispredict counter, plus RAM write enables.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    perf_d  = perf_q;
    tag_we  = 1'b0;
    tgt_we  = 1'b0;
    up_hit  = valid_q[up_idx] && (tag_ram[up_idx] == up_tag);

    if (bus.upd_valid) begin
      if (bus.upd_is_jump) begin
        // Jumps always (re)allocate as strongly taken.
        valid_d[up_idx] = 1'b1;
        cnt_d[up_cidx]  = CNT_MAX;
        tag_we          = 1'b1;
        tgt_we          = 1'b1;
      end else if (up_hit) begin
        if (bus.upd_taken) begin
          cnt_d[up_cidx] = cnt_sat_inc(cnt_q[up_cidx]);
          tgt_we         = 1'b1;
        end else begin
          cnt_d[up_cidx] = cnt_sat_dec(cnt_q[up_cidx]);
        end
      end else if (bus.upd_taken) begin
        // Allocate-on-taken; evicts whatever aliased into this slot.
        valid_d[up_idx] = 1'b1;
        cnt_d[up_cidx]  = CNT_WT;
        tag_we          = 1'b1;
        tgt_we          = 1'b1;
      end

      if (bus.upd_mispredict) begin
        perf_d = perf_sat_inc(perf_q);
      end
    end
  end

  // Control state with asynchronous reset; an update racing reset is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      cnt_q   <= {DEPTH{CNT_WNT}};
      perf_q  <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  // Tag/target storage: no reset, writes suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && tag_we) begin
      tag_ram[up_idx] <= up_tag;
    end
    if (reset_n && tgt_we) begin
      tgt_ram[up_idx] <= bus.upd_target;
    end
  end

endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Randomised + directed bench for btb_bimodal_predictor (default parameters,
// bimodal build) against a table-level reference model.
module tb_btb_bimodal_predictor;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  btb_bimodal_predictor_if #(.WORD_W(16)) bus ();

  btb_bimodal_predictor #(
    .WORD_W(16), .IDX_W(8), .TAG_W(8), .CNT_W(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per BTB slot, counter held as an integer 0..3.
  bit        m_valid [256];
  bit [7:0]  m_tag   [256];
  bit [15:0] m_tgt   [256];
  int        m_cnt   [256];
  int        m_perf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 1;
    end
    m_perf = 0;
  endtask

  task automatic model_update(input bit [15:0] upc, input bit j, input bit t,
                              input bit [15:0] tgt, input bit mp);
    int  i;
    bit  hit;
    i   = upc % 256;
    hit = m_valid[i] && (m_tag[i] == upc / 256);
    if (j) begin
      m_valid[i] = 1; m_tag[i] = upc / 256; m_tgt[i] = tgt; m_cnt[i] = 3;
    end else if (hit) begin
      if (t) begin
        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (t) begin
      m_valid[i] = 1; m_tag[i] = upc / 256; m_tgt[i] = tgt; m_cnt[i] = 2;
    end
    if (mp) m_perf = (m_perf < 65535) ? m_perf + 1 : 65535;
  endtask

  task automatic check_lookup(input string tg);
    int  i;
    bit  hit, taken;
    int  npc;
    i     = bus.pc % 256;
    hit   = m_valid[i] && (m_tag[i] == bus.pc / 256);
    taken = hit && (m_cnt[i] >= 2);
    npc   = taken ? int'(m_tgt[i]) : (int'(bus.pc) + 1) % 65536;
    chk({tg, "_hit"},   32'(bus.pred_hit),     32'(hit));
    chk({tg, "_taken"}, 32'(bus.pred_taken),   32'(taken));
    chk({tg, "_npc"},   32'(bus.pred_next_pc), 32'(npc));
    chk({tg, "_perf"},  32'(bus.perf_mispred), 32'(m_perf));
  endtask

  task automatic drive(input bit v, input bit [15:0] upc, input bit j, input bit t,
                       input bit [15:0] tgt, input bit mp, input bit [15:0] lpc);
    bus.upd_valid      = v;
    bus.upd_pc         = upc;
    bus.upd_is_jump    = j;
    bus.upd_taken      = t;
    bus.upd_target     = tgt;
    bus.upd_mispredict = mp;
    bus.pc             = lpc;
  endtask

  // One clock: the model absorbs whatever update the DUT commits at this edge.
  task automatic tick();
    @(posedge clk);
    if (bus.upd_valid && reset_n)
      model_update(bus.upd_pc, bus.upd_is_jump, bus.upd_taken, bus.upd_target, bus.upd_mispredict);
    @(negedge clk);
  endtask

  // Look up lpc (checked against model, pre-update), then commit an update.
  task automatic step(input string tg, input bit v, input bit [15:0] upc, input bit j,
                      input bit t, input bit [15:0] tgt, input bit mp, input bit [15:0] lpc);
    drive(v, upc, j, t, tgt, mp, lpc);
    #1;
    check_lookup(tg);
    tick();
  endtask

  task automatic look(input string tg, input bit [15:0] lpc);
    drive(0, 16'h0, 0, 0, 16'h0, 0, lpc);
    #1;
    check_lookup(tg);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    model_reset();
    drive(0, 16'h0, 0, 0, 16'h0, 0, 16'h0010);
    repeat (2) @(negedge clk);

    // Reset state and wrap-around
    #1;
    check_lookup("rst");
    chk("rst_npc_const", 32'(bus.pred_next_pc), 32'h0011);
    reset_n = 1'b1;
    look("t1_a", 16'h0010);
    look("t1_wrap", 16'hFFFF);
    chk("t1_wrap_const", 32'(bus.pred_next_pc), 32'h0000);

    // Not-taken miss must not allocate; taken miss allocates weakly taken
    step("t2_nt", 1, 16'h0010, 0, 0, 16'h0040, 0, 16'h0010);
    look("t2_noalloc", 16'h0010);
    chk("t2_noalloc_const", 32'(bus.pred_hit), 32'h0);
    step("t2_tk", 1, 16'h0010, 0, 1, 16'h0040, 0, 16'h0010);
    look("t2_hit", 16'h0010);
    chk("t2_npc_const", 32'(bus.pred_next_pc), 32'h0040);

    // Counter walks down to 0 and saturates at 3 going up
    step("t3_d1", 1, 16'h0010, 0, 0, 16'h0040, 0, 16'h0010);
    step("t3_d2", 1, 16'h0010, 0, 0, 16'h0040, 0, 16'h0010);
    look("t3_low", 16'h0010);
    chk("t3_low_const", 32'(bus.pred_next_pc), 32'h0011);
    for (int k = 0; k < 4; k++) step($sformatf("t3_u%0d", k), 1, 16'h0010, 0, 1, 16'h0040, 0, 16'h0010);
    step("t3_sat_nt", 1, 16'h0010, 0, 0, 16'h0040, 0, 16'h0010);
    look("t3_after", 16'h0010);

    // Aliasing entry replaces the old one
    look("t4_alias_miss", 16'h0110);
    step("t4_alloc", 1, 16'h0110, 0, 1, 16'h0200, 0, 16'h0110);
    look("t4_new", 16'h0110);
    chk("t4_new_const", 32'(bus.pred_next_pc), 32'h0200);
    look("t4_old", 16'h0010);
    chk("t4_old_const", 32'(bus.pred_hit), 32'h0);

    // Jump allocates strongly taken; async reset clears it immediately
    step("t5_jmp", 1, 16'h0020, 1, 0, 16'h0005, 0, 16'h0020);
    look("t5_jhit", 16'h0020);
    chk("t5_j_const", 32'(bus.pred_next_pc), 32'h0005);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check_lookup("t5_rst");
    chk("t5_rst_const", 32'(bus.pred_next_pc), 32'h0021);
    reset_n = 1'b1;
    tick();

    // Same-cycle lookup/update: no bypass
    drive(1, 16'h0030, 0, 1, 16'h0090, 0, 16'h0030);
    #1;
    check_lookup("t6_same");
    chk("t6_same_const", 32'(bus.pred_next_pc), 32'h0031);
    tick();
    look("t6_next", 16'h0030);
    chk("t6_next_const", 32'(bus.pred_next_pc), 32'h0090);

    // Mispredict counter saturation (not-taken misses: no table change)
    drive(1, 16'h7777, 0, 0, 16'h0, 1, 16'h0030);
    for (int k = 0; k < 65535; k++) tick();
    look("t6_perf_full", 16'h0030);
    chk("t6_perf_const", 32'(bus.perf_mispred), 32'hFFFF);
    drive(1, 16'h7777, 0, 0, 16'h0, 1, 16'h0030);
    for (int k = 0; k < 6; k++) tick();
    look("t6_perf_hold", 16'h0030);
    chk("t6_perf_hold_const", 32'(bus.perf_mispred), 32'hFFFF);

    // Randomised traffic on a small address pool to force hits and aliases
    reset_n = 1'b0;
    model_reset();
    #1 reset_n = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      bit [15:0] lpc, upc;
      lpc = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
      upc = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
      if ($urandom_range(0, 15) == 0) lpc = 16'($urandom);
      drive($urandom_range(0, 9) < 7, upc, $urandom_range(0, 5) == 0, 1'($urandom),
            16'($urandom), 1'($urandom), lpc);
      #1;
      check_lookup("rnd");
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        check_lookup("rnd_rst");
        reset_n = 1'b1;
      end
      tick();
    end
    look("final", 16'h0003);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btb_bimodal_predictor.md
Name: btb_bimodal_predictor

Overview:
Parametrised successor to the single-table fetch-stage predictor. Provides a direct-mapped BTB with per-entry valid bits and tags, plus an N-bit saturating direction counter per entry. Lookup is combinational on the IF-stage PC. Updates arrive from the branch-resolve stage and are committed on the clock edge. Adds what the previous block lacked: real valid bits with async reset, allocate-on-taken, jump handling, a live update path, and a mispredict performance counter.

Parameters:
WORD_W  16  instruction/PC width (matches `WORD_SIZE)
IDX_W   8   index bits; table depth = 2**IDX_W
TAG_W   8   tag bits taken from pc[IDX_W+TAG_W-1:IDX_W]; IDX_W+TAG_W <= WORD_W is required
CNT_W   2   direction counter width; CNT_W >= 1

Ports:
clk            in   1       clock, all state updates on posedge
reset_n        in   1       asynchronous, active-low reset
pc             in   WORD_W  IF-stage PC to predict
pred_next_pc   out  WORD_W  predicted next fetch PC
pred_hit       out  1       valid entry with matching tag
pred_taken     out  1       hit and counter MSB = 1
upd_valid      in   1       commit one resolved control instruction this cycle
upd_pc         in   WORD_W  PC of the resolved instruction
upd_is_jump    in   1       1 = unconditional (JMP/JAL/JPR/JRL); 0 = conditional branch
upd_taken      in   1       actual direction (ignored when upd_is_jump = 1; treated as taken)
upd_target     in   WORD_W  actual taken target
upd_mispredict in   1       the resolve stage flushed for this instruction
perf_mispred   out  16      saturating count of upd_valid & upd_mispredict

Behaviour:
- Lookup is purely combinational, zero latency.
  - idx = pc[IDX_W-1:0]; tag = pc[IDX_W+TAG_W-1:IDX_W].
  - pred_hit = valid[idx] & (tag_ram[idx] == tag).
  - pred_taken = pred_hit & cnt[idx][CNT_W-1].
  - pred_next_pc = pred_taken ? tgt_ram[idx] : pc + 1. Arithmetic is mod 2**WORD_W, so 0xFFFF + 1 = 0x0000.
- Reset (async, any time, including mid-update):
  - All valid bits = 0.
  - All counters = 2**(CNT_W-1) - 1 (weakly not-taken).
  - perf_mispred = 0.
  - Tag and target RAMs are not reset.
  - An update coincident with reset assertion is dropped.
- Update on posedge clk when upd_valid = 1. Index and tag are derived from upd_pc.
  - Hit, conditional branch:
    - Counter saturates: +1 if taken (stops at 2**CNT_W-1), -1 if not taken (stops at 0).
    - If taken, tgt_ram is rewritten with upd_target.
  - Hit, jump: counter is forced to all-ones; target is rewritten.
  - Miss, taken conditional branch: allocate. valid = 1, tag written, target written, counter = 2**(CNT_W-1) (weakly taken). This replaces any aliasing entry.
  - Miss, jump: allocate with counter = all-ones.
  - Miss, not-taken conditional branch: no state change (no allocation).
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents (no bypass). The new contents are visible from the next cycle.
- perf_mispred increments on upd_valid & upd_mispredict and holds at 0xFFFF.
- No back-pressure: one update is accepted per cycle, always.

Optional Feature:
Macro BTB_GSHARE_EN.
- When defined:
  - Adds an IDX_W-bit global history register ghr, reset to 0.
  - The direction counter table is indexed by idx ^ ghr for both lookup and update. Tag, target and valid bits still use the plain idx.
  - On an upd_valid conditional-branch update, ghr <= {ghr[IDX_W-2:0], upd_taken} on the same edge; jumps do not shift ghr.
  - The counter read for an update uses the pre-shift ghr.
- When undefined: no ghr exists; the counter is indexed by idx (bimodal). The port list is identical in both builds.

Test Plan:
(all at defaults IDX_W=8, TAG_W=8, CNT_W=2, gshare off)
1. Release reset, pc=0x0010 -> pred_hit=0, pred_taken=0, pred_next_pc=0x0011; pc=0xFFFF -> pred_next_pc=0x0000.
2. Update pc=0x0010, branch, taken, target=0x0040; next cycle pc=0x0010 -> hit=1, taken=1 (cnt=10), next_pc=0x0040. Same pc with no prior update but not-taken update -> still hit=0.
3. From step 2, two not-taken updates -> cnt 10->01->00, pred_next_pc=0x0011, hit=1. Three taken updates -> cnt 11 (saturated), a 4th stays 11.
4. Alias: after step 2, pc=0x0110 -> hit=0, next_pc=0x0111. Taken update at 0x0110 -> target 0x0200 replaces the entry; pc=0x0010 now misses.
5. Jump update pc=0x0020 target=0x0005 -> cnt=11, next_pc=0x0005. Then pulse reset_n low mid-cycle -> pc=0x0020 immediately gives hit=0, next_pc=0x0021.
6. Same cycle: pc=0x0030 lookup and taken update at 0x0030 target 0x0090 -> that cycle next_pc=0x0031, following cycle 0x0090. 0x10005 mispredict updates -> perf_mispred=0xFFFF.
